// File: rtl/fpu_op_driver.sv
// Initiator for the fpu operand/result interface: latches an operand pair, pulses the fpu
// reset, waits for a nonzero status (or timeout), then hands the captured result back.
module fpu_op_driver #(
    parameter int unsigned MIN_WAIT = 2,
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock100KHz,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_op_a,
    input  logic [31:0]      req_op_b,
    output logic [31:0]      op_A_out,
    output logic [31:0]      op_B_out,
    output logic             fpu_reset,
    input  logic [31:0]      fpu_data_in,
    input  logic [3:0]       fpu_status_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_status,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned WCW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {StIdle, StKick, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             fpu_reset_q, fpu_reset_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_status_q, rsp_status_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             done, timeout;

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            op_a_q        <= '0;
            op_b_q        <= '0;
            fpu_reset_q   <= 1'b1;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            fpu_reset_q   <= fpu_reset_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
            op_count_q    <= op_count_d;
        end
    end

    // Status is meaningless while the fpu is still held in reset, so sampling waits for release.
    assign done    = !fpu_reset_q && (wait_cnt_q >= WCW'(MIN_WAIT)) && (fpu_status_in != 4'd0);
    assign timeout = !fpu_reset_q && !done && (wait_cnt_q == WCW'(MAX_WAIT - 1));

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        fpu_reset_d   = 1'b0;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;
        op_count_d    = op_count_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_a_d  = req_op_a;
                    op_b_d  = req_op_b;
                    state_d = StKick;
                end
            end
            StKick: begin
                fpu_reset_d = 1'b1;
                wait_cnt_d  = '0;
                state_d     = StWait;
            end
            StWait: begin
                // The first WAIT cycle overlaps the reset pulse; counting starts after it.
                if (done || timeout) begin
                    rsp_data_d    = fpu_data_in;
                    rsp_status_d  = fpu_status_in;
                    rsp_timeout_d = timeout;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end else if (!fpu_reset_q) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready   = (state_q == StIdle);
    assign op_A_out    = op_a_q;
    assign op_B_out    = op_b_q;
    assign fpu_reset   = fpu_reset_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_timeout = rsp_timeout_q;
    assign op_count    = op_count_q;

endmodule
